// File: rtl/answer_checker_fsm.sv
// Answer checker: synchronises switch/button inputs, decodes the switch code
// through a parameter table and scores each submission against the target IN.
module answer_checker_fsm #(
  parameter int CODE_W      = 5,
  parameter int VAL_W       = 4,
  parameter int NUM_CODES   = 10,
  parameter logic [NUM_CODES*CODE_W-1:0] CODE_TABLE =
    {5'b10001, 5'b11111, 5'b10101, 5'b10100, 5'b11010,
     5'b01001, 5'b10011, 5'b10101, 5'b01101, 5'b11101},
  parameter int SCORE_W     = 4,
  parameter int ROUNDS      = 10,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                           CLK,
  input  logic                           R_N,
  input  logic                           BTN,
  input  logic [CODE_W-1:0]              SW,
  input  logic [VAL_W-1:0]               IN,
  input  logic                           NEW_GAME,
  output logic [SCORE_W-1:0]             NUM_CORRECT,
  output logic [SCORE_W-1:0]             NUM_WRONG,
  output logic [$clog2(ROUNDS+1)-1:0]    ROUND,
  output logic                           RESULT_VALID,
  output logic                           CORRECT,
  output logic                           INVALID,
  output logic [VAL_W-1:0]               DECODED,
  output logic                           GAME_OVER,
  output logic                           BUSY
);

  // state | meaning
  // READY | waiting for a submit pulse
  // HOLD  | lockout after a submission, presses dropped
  // OVER  | ROUNDS submissions taken, waiting for NEW_GAME
  typedef enum logic [1:0] {READY, HOLD, OVER} state_t;

  localparam int RND_W  = $clog2(ROUNDS+1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES+1);

  logic                btn_s1_q, btn_s2_q, btn_s3_q;
  logic [CODE_W-1:0]   sw_s1_q, sw_s2_q;
  logic                sub;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [SCORE_W-1:0]  ncor_q, ncor_d, nwr_q, nwr_d;
  logic [RND_W-1:0]    round_q, round_d;
  logic                rv_q, rv_d, cor_q, cor_d, inv_q, inv_d;
  logic [VAL_W-1:0]    dec_q, dec_d;

  logic                dec_hit;
  logic [VAL_W-1:0]    dec_val;
  logic                is_match;

  always_ff @(posedge CLK or negedge R_N) begin
    if (!R_N) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      btn_s3_q <= 1'b0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      btn_s1_q <= BTN;
      btn_s2_q <= btn_s1_q;
      btn_s3_q <= btn_s2_q;
      sw_s1_q  <= SW;
      sw_s2_q  <= sw_s1_q;
    end
  end

  assign sub = btn_s2_q & ~btn_s3_q;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    dec_hit = 1'b0;
    dec_val = '0;
    for (int i = NUM_CODES-1; i >= 0; i--) begin
      if (sw_s2_q == CODE_TABLE[i*CODE_W +: CODE_W]) begin
        dec_hit = 1'b1;
        dec_val = VAL_W'(i+1);
      end
    end
  end

  assign is_match = dec_hit && (dec_val == IN);

  always_ff @(posedge CLK or negedge R_N) begin
    if (!R_N) begin
      state_q <= READY;
      hold_q  <= '0;
      ncor_q  <= '0;
      nwr_q   <= '0;
      round_q <= '0;
      rv_q    <= 1'b0;
      cor_q   <= 1'b0;
      inv_q   <= 1'b0;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ncor_q  <= ncor_d;
      nwr_q   <= nwr_d;
      round_q <= round_d;
      rv_q    <= rv_d;
      cor_q   <= cor_d;
      inv_q   <= inv_d;
      dec_q   <= dec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ncor_d  = ncor_q;
    nwr_d   = nwr_q;
    round_d = round_q;
    rv_d    = 1'b0;
    cor_d   = cor_q;
    inv_d   = inv_q;
    dec_d   = dec_q;

    if (NEW_GAME) begin
      state_d = READY;
      hold_d  = '0;
      ncor_d  = '0;
      nwr_d   = '0;
      round_d = '0;
      cor_d   = 1'b0;
      inv_d   = 1'b0;
      dec_d   = '0;
    end else begin
      case (state_q)
        READY: begin
          if (sub) begin
            rv_d    = 1'b1;
            round_d = round_q + 1'b1;
            dec_d   = dec_hit ? dec_val : '0;
            inv_d   = ~dec_hit;
            cor_d   = is_match;
            if (is_match) begin
              if (ncor_q != '1) ncor_d = ncor_q + 1'b1;
            end else begin
              if (nwr_q != '1) nwr_d = nwr_q + 1'b1;
            end
            hold_d  = HOLD_W'(HOLD_CYCLES-1);
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (hold_q == '0) begin
            state_d = (round_q == RND_W'(ROUNDS)) ? OVER : READY;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
        OVER: begin
          state_d = OVER;
        end
        default: begin
          state_d = READY;
        end
      endcase
    end
  end

  assign NUM_CORRECT  = ncor_q;
  assign NUM_WRONG    = nwr_q;
  assign ROUND        = round_q;
  assign RESULT_VALID = rv_q;
  assign CORRECT      = cor_q;
  assign INVALID      = inv_q;
  assign DECODED      = dec_q;
  assign GAME_OVER    = (state_q == OVER);
  assign BUSY         = (state_q != READY);

endmodule

// File: tb/tb_answer_checker_fsm.sv
// Scoreboard bench for answer_checker_fsm: a default instance plus a
// SCORE_W=2 instance sharing stimulus to exercise counter saturation.
module tb_answer_checker_fsm;

  logic       CLK = 1'b0;
  logic       R_N, BTN, NEW_GAME;
  logic [4:0] SW;
  logic [3:0] IN;

  logic [3:0] NUM_CORRECT, NUM_WRONG, DECODED;
  logic [3:0] ROUND;
  logic       RESULT_VALID, CORRECT, INVALID, GAME_OVER, BUSY;

  logic [1:0] NUM_CORRECT2, NUM_WRONG2;
  logic [3:0] ROUND2, DECODED2;
  logic       RESULT_VALID2, CORRECT2, INVALID2, GAME_OVER2, BUSY2;

  always #5 CLK = ~CLK;

  answer_checker_fsm dut (
    .CLK(CLK), .R_N(R_N), .BTN(BTN), .SW(SW), .IN(IN), .NEW_GAME(NEW_GAME),
    .NUM_CORRECT(NUM_CORRECT), .NUM_WRONG(NUM_WRONG), .ROUND(ROUND),
    .RESULT_VALID(RESULT_VALID), .CORRECT(CORRECT), .INVALID(INVALID),
    .DECODED(DECODED), .GAME_OVER(GAME_OVER), .BUSY(BUSY)
  );

  answer_checker_fsm #(.SCORE_W(2)) dut2 (
    .CLK(CLK), .R_N(R_N), .BTN(BTN), .SW(SW), .IN(IN), .NEW_GAME(NEW_GAME),
    .NUM_CORRECT(NUM_CORRECT2), .NUM_WRONG(NUM_WRONG2), .ROUND(ROUND2),
    .RESULT_VALID(RESULT_VALID2), .CORRECT(CORRECT2), .INVALID(INVALID2),
    .DECODED(DECODED2), .GAME_OVER(GAME_OVER2), .BUSY(BUSY2)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Code table in index order; entry i decodes to i+1.
  logic [4:0] tbl [10] = '{5'b11101, 5'b01101, 5'b10101, 5'b10011, 5'b01001,
                           5'b11010, 5'b10100, 5'b10101, 5'b11111, 5'b10001};

  function automatic int dec_of(input logic [4:0] c);
    for (int i = 0; i < 10; i++) if (tbl[i] == c) return i + 1;
    return 0;
  endfunction

  typedef struct {
    int dec; int inv; int cor; int ncor; int nwr; int rnd; int ncor2; int nwr2;
  } exp_t;
  exp_t sb[$];

  int m_cor, m_wr, m_cor2, m_wr2, m_round;
  bit m_over;

  task automatic model_clear();
    m_cor = 0; m_wr = 0; m_cor2 = 0; m_wr2 = 0; m_round = 0; m_over = 0;
  endtask

  task automatic push_expect(input logic [4:0] code, input logic [3:0] val);
    exp_t e;
    int d;
    if (m_over) return;
    d = dec_of(code);
    e.dec = d;
    e.inv = (d == 0) ? 1 : 0;
    e.cor = (d != 0 && d == int'(val)) ? 1 : 0;
    if (e.cor != 0) begin
      if (m_cor < 15) m_cor++;
      if (m_cor2 < 3) m_cor2++;
    end else begin
      if (m_wr < 15) m_wr++;
      if (m_wr2 < 3) m_wr2++;
    end
    m_round++;
    if (m_round == 10) m_over = 1;
    e.ncor = m_cor; e.nwr = m_wr; e.rnd = m_round;
    e.ncor2 = m_cor2; e.nwr2 = m_wr2;
    sb.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (R_N && RESULT_VALID) begin
      if (sb.size() == 0) begin
        chk("unexpected_rv", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("decoded",  DECODED,       e.dec);
        chk("invalid",  INVALID,       e.inv);
        chk("correct",  CORRECT,       e.cor);
        chk("num_cor",  NUM_CORRECT,   e.ncor);
        chk("num_wr",   NUM_WRONG,     e.nwr);
        chk("round",    ROUND,         e.rnd);
        chk("num_cor2", NUM_CORRECT2,  e.ncor2);
        chk("num_wr2",  NUM_WRONG2,    e.nwr2);
        chk("rv2",      RESULT_VALID2, 1);
      end
    end
  end

  task automatic press(input logic [4:0] code, input logic [3:0] val, input int hold_n);
    @(negedge CLK);
    SW = code; IN = val; BTN = 1'b1;
    push_expect(code, val);
    repeat (hold_n) @(negedge CLK);
    BTN = 1'b0;
    repeat (10) @(negedge CLK);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    R_N = 1'b0; BTN = 1'b0; SW = '0; IN = '0; NEW_GAME = 1'b0;
    model_clear();
    repeat (3) @(negedge CLK);
    chk("rst_ncor",  NUM_CORRECT, 0);
    chk("rst_nwr",   NUM_WRONG, 0);
    chk("rst_round", ROUND, 0);
    chk("rst_rv",    RESULT_VALID, 0);
    chk("rst_flags", {CORRECT, INVALID, GAME_OVER, BUSY}, 0);
    chk("rst_dec",   DECODED, 0);
    R_N = 1'b1;
    repeat (2) @(negedge CLK);

    // correct first answer, latency and lockout length
    SW = 5'b11101; IN = 4'd1; BTN = 1'b1;
    push_expect(5'b11101, 4'd1);
    @(negedge CLK);
    BTN = 1'b0;
    n = 0;
    while (!RESULT_VALID && n < 20) begin @(negedge CLK); n++; end
    chk("rv_latency", n, 2);
    n = 0;
    while (BUSY && n < 20) begin n++; @(negedge CLK); end
    chk("busy_len", n, 4);
    repeat (4) @(negedge CLK);
    chk("sb_empty", sb.size(), 0);

    // duplicate code resolves to lowest index, then an invalid code
    press(5'b10101, 4'd8, 1);
    press(5'b00000, 4'd8, 1);

    // second rise during HOLD is dropped
    @(negedge CLK);
    SW = 5'b11101; IN = 4'd1; BTN = 1'b1;
    push_expect(5'b11101, 4'd1);
    @(negedge CLK); BTN = 1'b0;
    @(negedge CLK); BTN = 1'b1;
    @(negedge CLK); BTN = 1'b0;
    repeat (10) @(negedge CLK);
    chk("sb_empty", sb.size(), 0);
    chk("hold_round", ROUND, 4);

    // long hold gives one submission
    press(5'b01101, 4'd2, 50);

    // saturation on the narrow instance
    press(5'b10011, 4'd4, 1);
    press(5'b01001, 4'd5, 1);
    press(5'b10001, 4'd10, 1);
    chk("sat_cor2", NUM_CORRECT2, 3);
    chk("wide_cor", NUM_CORRECT, 6);

    // finish the game
    press(5'b11111, 4'd9, 1);
    press(5'b11010, 4'd3, 1);
    chk("game_over", GAME_OVER, 1);
    chk("over_busy", BUSY, 1);
    press(5'b11101, 4'd1, 1);
    chk("over_round", ROUND, 10);
    chk("over_hold", GAME_OVER, 1);

    @(negedge CLK); NEW_GAME = 1'b1;
    @(negedge CLK); NEW_GAME = 1'b0;
    model_clear();
    chk("ng_ncor",  NUM_CORRECT, 0);
    chk("ng_nwr",   NUM_WRONG, 0);
    chk("ng_round", ROUND, 0);
    chk("ng_over",  GAME_OVER, 0);
    chk("ng_flags", {CORRECT, INVALID, DECODED}, 0);
    press(5'b10100, 4'd7, 1);

    // NEW_GAME on the same edge as the submit pulse
    @(negedge CLK); SW = 5'b11101; IN = 4'd1; BTN = 1'b1;
    @(negedge CLK); BTN = 1'b0;
    @(negedge CLK); NEW_GAME = 1'b1;
    @(negedge CLK); NEW_GAME = 1'b0;
    model_clear();
    repeat (8) @(negedge CLK);
    chk("coin_ncor",  NUM_CORRECT, 0);
    chk("coin_round", ROUND, 0);
    chk("coin_busy",  BUSY, 0);
    chk("sb_empty", sb.size(), 0);

    // async reset in the middle of HOLD
    @(negedge CLK); SW = 5'b11101; IN = 4'd1; BTN = 1'b1;
    push_expect(5'b11101, 4'd1);
    @(negedge CLK); BTN = 1'b0;
    n = 0;
    while (!RESULT_VALID && n < 20) begin @(negedge CLK); n++; end
    chk("rst_rv_seen", RESULT_VALID, 1);
    @(negedge CLK);
    R_N = 1'b0;
    #1;
    chk("arst_ncor",  NUM_CORRECT, 0);
    chk("arst_round", ROUND, 0);
    chk("arst_busy",  BUSY, 0);
    chk("arst_flags", {CORRECT, INVALID, DECODED}, 0);
    @(negedge CLK); R_N = 1'b1;
    model_clear();
    press(5'b10101, 4'd3, 1);
    chk("post_rst_round", ROUND, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
